// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction-fetch front end.
package fetch_pkg;

   localparam int XLEN_DEF       = 32;
   localparam int INSN_WIDTH_DEF = 32;

   typedef enum logic [1:0] {
      FS_RUN,
      FS_WAIT,
      FS_DRAIN
   } fetch_state_e;

   typedef struct packed {
      logic [XLEN_DEF-1:0]       pc;
      logic [INSN_WIDTH_DEF-1:0] insn;
   } fetch_entry_t;

   // Slot-offset width; a 1-wide block still gets one (always zero) bit.
   function automatic int off_width(input int fw);
      return (fw > 1) ? $clog2(fw) : 1;
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular fetch queue: up to FETCH_WIDTH pushes per cycle, one pop, flush.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter  int XLEN        = XLEN_DEF,
   parameter  int INSN_WIDTH  = INSN_WIDTH_DEF,
   parameter  int FETCH_WIDTH = 2,
   parameter  int FQ_DEPTH    = 8,
   localparam int PTR_W       = $clog2(FQ_DEPTH),
   localparam int CNT_W       = PTR_W + 1,
   localparam int OFF_W       = off_width(FETCH_WIDTH),
   localparam int PCNT_W      = $clog2(FETCH_WIDTH + 1)
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              flush_i,
   input  logic [PCNT_W-1:0]                 push_cnt_i,
   input  logic [OFF_W-1:0]                  push_start_i,
   input  logic [XLEN-1:0]                   push_base_i,
   input  logic [FETCH_WIDTH*INSN_WIDTH-1:0] push_data_i,
   input  logic                              pop_i,
   output logic [CNT_W-1:0]                  count_o,
   output logic                              valid_o,
   output logic [INSN_WIDTH-1:0]             head_insn_o,
   output logic [XLEN-1:0]                   head_pc_o
);

   logic [INSN_WIDTH-1:0] insn_q [FQ_DEPTH];
   logic [XLEN-1:0]       pc_q   [FQ_DEPTH];
   logic [PTR_W-1:0]      head_q;
   logic [PTR_W-1:0]      tail_q;
   logic [CNT_W-1:0]      count_q;
   logic                  pop;

   assign valid_o     = (count_q != '0);
   assign pop         = pop_i && valid_o;
   assign count_o     = count_q;
   assign head_insn_o = valid_o ? insn_q[head_q] : '0;
   assign head_pc_o   = valid_o ? pc_q[head_q]   : '0;

   always_ff @(posedge clk) begin
      if (rst || flush_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_q + PTR_W'(pop);
         tail_q  <= tail_q + PTR_W'(push_cnt_i);
         count_q <= count_q + CNT_W'(push_cnt_i) - CNT_W'(pop);
      end
   end

   // Storage is not reset; empty-queue outputs are forced to zero above.
   always_ff @(posedge clk) begin
      if (!rst && !flush_i) begin
         for (int k = 0; k < FETCH_WIDTH; k++) begin
            if (k < int'(push_cnt_i)) begin
               insn_q[tail_q + PTR_W'(k)] <=
                  push_data_i[(int'(push_start_i) + k)*INSN_WIDTH +: INSN_WIDTH];
               pc_q[tail_q + PTR_W'(k)] <=
                  push_base_i + XLEN'(int'(push_start_i) + k);
            end
         end
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC, epoch, request FSM, fetch queue.
// Define FETCH_PERF_CNT_EN to add the perf_* counter outputs.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int XLEN        = XLEN_DEF,
   parameter int INSN_WIDTH  = INSN_WIDTH_DEF,
   parameter int FETCH_WIDTH = 2,
   parameter int FQ_DEPTH    = 8,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              redirect_valid,
   input  logic [XLEN-1:0]                   redirect_pc,
   output logic                              imem_req_valid,
   input  logic                              imem_req_ready,
   output logic [XLEN-1:0]                   imem_req_addr,
   input  logic                              imem_resp_valid,
   input  logic [FETCH_WIDTH*INSN_WIDTH-1:0] imem_resp_data,
   output logic                              dec_valid,
   input  logic                              dec_ready,
   output logic [INSN_WIDTH-1:0]             dec_insn,
   output logic [XLEN-1:0]                   dec_pc
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]                       perf_insn_pushed,
   output logic [31:0]                       perf_stall_full,
   output logic [31:0]                       perf_resp_dropped
`endif
);

   localparam int PTR_W  = $clog2(FQ_DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int OFF_W  = off_width(FETCH_WIDTH);
   localparam int PCNT_W = $clog2(FETCH_WIDTH + 1);

   fetch_state_e     state_q, state_d;
   logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
   logic             epoch_q, epoch_d;
   logic             req_epoch_q, req_epoch_d;
   logic [OFF_W-1:0] req_offset_q, req_offset_d;
   logic [XLEN-1:0]  req_blk_q, req_blk_d;

   logic [XLEN-1:0]   blk_addr;
   logic [OFF_W-1:0]  pc_off;
   logic [CNT_W-1:0]  fq_count;
   logic              free_ok;
   logic              req_valid;
   logic [PCNT_W-1:0] push_cnt;
   logic              stall_full;
   logic              resp_drop;

   assign blk_addr = fetch_pc_q & ~XLEN'(FETCH_WIDTH - 1);
   assign pc_off   = OFF_W'(fetch_pc_q & XLEN'(FETCH_WIDTH - 1));
   assign free_ok  = (CNT_W'(FQ_DEPTH) - fq_count) >= CNT_W'(FETCH_WIDTH);

   assign imem_req_valid = req_valid;
   assign imem_req_addr  = blk_addr;

   always_comb begin
      state_d      = state_q;
      fetch_pc_d   = fetch_pc_q;
      epoch_d      = epoch_q;
      req_epoch_d  = req_epoch_q;
      req_offset_d = req_offset_q;
      req_blk_d    = req_blk_q;
      req_valid    = 1'b0;
      push_cnt     = '0;
      stall_full   = 1'b0;
      resp_drop    = 1'b0;
      unique case (state_q)
         FS_RUN: begin
            req_valid  = !rst && free_ok && !redirect_valid;
            stall_full = !rst && !free_ok;
            if (req_valid && imem_req_ready) begin
               req_epoch_d  = epoch_q;
               req_offset_d = pc_off;
               req_blk_d    = blk_addr;
               fetch_pc_d   = blk_addr + XLEN'(FETCH_WIDTH);
               state_d      = FS_WAIT;
            end
         end
         FS_WAIT: begin
            // A response in the redirect cycle retires the request outright.
            if (imem_resp_valid) begin
               state_d = FS_RUN;
               if (redirect_valid || (req_epoch_q != epoch_q)) begin
                  resp_drop = 1'b1;
               end else begin
                  push_cnt = PCNT_W'(FETCH_WIDTH - int'(req_offset_q));
               end
            end else if (redirect_valid) begin
               state_d = FS_DRAIN;
            end
         end
         FS_DRAIN: begin
            if (imem_resp_valid) begin
               state_d   = FS_RUN;
               resp_drop = 1'b1;
            end
         end
         default: state_d = FS_RUN;
      endcase
      if (redirect_valid) begin
         epoch_d    = ~epoch_q;
         fetch_pc_d = redirect_pc;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= FS_RUN;
         fetch_pc_q   <= RESET_PC;
         epoch_q      <= 1'b0;
         req_epoch_q  <= 1'b0;
         req_offset_q <= '0;
         req_blk_q    <= '0;
      end else begin
         state_q      <= state_d;
         fetch_pc_q   <= fetch_pc_d;
         epoch_q      <= epoch_d;
         req_epoch_q  <= req_epoch_d;
         req_offset_q <= req_offset_d;
         req_blk_q    <= req_blk_d;
      end
   end

   fetch_queue #(
      .XLEN        (XLEN),
      .INSN_WIDTH  (INSN_WIDTH),
      .FETCH_WIDTH (FETCH_WIDTH),
      .FQ_DEPTH    (FQ_DEPTH)
   ) u_queue (
      .clk          (clk),
      .rst          (rst),
      .flush_i      (redirect_valid),
      .push_cnt_i   (push_cnt),
      .push_start_i (req_offset_q),
      .push_base_i  (req_blk_q),
      .push_data_i  (imem_resp_data),
      .pop_i        (dec_ready),
      .count_o      (fq_count),
      .valid_o      (dec_valid),
      .head_insn_o  (dec_insn),
      .head_pc_o    (dec_pc)
   );

`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_insn_pushed  <= '0;
         perf_stall_full   <= '0;
         perf_resp_dropped <= '0;
      end else begin
         perf_insn_pushed  <= perf_insn_pushed + 32'(push_cnt);
         perf_stall_full   <= perf_stall_full + 32'(stall_full);
         perf_resp_dropped <= perf_resp_dropped + 32'(resp_drop);
      end
   end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit.
// FETCH_WIDTH=2, FQ_DEPTH=8.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int FW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          redirect_valid = 1'b0;
  logic [31:0]   redirect_pc = '0;
  logic          imem_req_valid;
  logic          imem_req_ready = 1'b1;
  logic [31:0]   imem_req_addr;
  logic          imem_resp_valid;
  logic [FW*32-1:0] imem_resp_data;
  logic          dec_valid;
  logic          dec_ready = 1'b1;
  logic [31:0]   dec_insn;
  logic [31:0]   dec_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]   perf_insn_pushed;
  logic [31:0]   perf_stall_full;
  logic [31:0]   perf_resp_dropped;
`endif

  int tests = 0;
  int fails = 0;

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    tests++;
    if (obs !== exp) begin
      fails++;
      $error("FAIL %s: got %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  fetch_unit #(.FETCH_WIDTH(FW), .FQ_DEPTH(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .dec_valid       (dec_valid),
    .dec_ready       (dec_ready),
    .dec_insn        (dec_insn),
    .dec_pc          (dec_pc)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_insn_pushed  (perf_insn_pushed),
    .perf_stall_full   (perf_stall_full),
    .perf_resp_dropped (perf_resp_dropped)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] insn_of(
    input logic [31:0] p
  );
    return {8'hA5, p[23:0]};
  endfunction

  int          mem_lat = 1;
  logic        pend = 1'b0;
  int          cnt = 0;
  logic [31:0] maddr = '0;

  assign imem_resp_valid = pend && (cnt == 0);

  always_comb begin
    imem_resp_data = '0;
    for (int i = 0; i < FW; i++)
      imem_resp_data[i*32 +: 32] =
        insn_of(maddr + 32'(i));
  end

  always @(posedge clk) begin
    if (rst) begin
      pend <= 1'b0;
    end else if (pend) begin
      if (cnt == 0) pend <= 1'b0;
      else cnt <= cnt - 1;
    end else if (imem_req_valid && imem_req_ready) begin
      pend  <= 1'b1;
      cnt   <= mem_lat - 1;
      maddr <= imem_req_addr;
    end
  end

  logic [31:0]  exp_pc = '0;
  int           pops = 0;
  fetch_entry_t exp_e;

  always @(negedge clk) begin
    if (!rst && dec_valid && dec_ready) begin
      exp_e = '{pc: exp_pc, insn: insn_of(exp_pc)};
      chk("dec_stream_pc", dec_pc, exp_e.pc);
      chk("dec_stream_insn", dec_insn, exp_e.insn);
      exp_pc = exp_pc + 1;
      pops++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fire(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (imem_req_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_dec(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (dec_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic drain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!pend && !dec_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    bit ok;
    int n;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_valid", imem_req_valid, 1'b0);
    chk("rst_dec_valid", dec_valid, 1'b0);
    chk("rst_dec_insn", dec_insn, 32'h0);
    chk("rst_dec_pc", dec_pc, 32'h0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("s1_req0_valid", imem_req_valid, 1'b1);
    chk("s1_req0_addr", imem_req_addr, 32'h0);
    chk("s1_c0_dec_valid", dec_valid, 1'b0);
    @(negedge clk);
    chk("s1_wait_req_valid", imem_req_valid, 1'b0);
    chk("s1_c1_dec_valid", dec_valid, 1'b0);
    @(negedge clk);
    chk("s1_req1_valid", imem_req_valid, 1'b1);
    chk("s1_req1_addr", imem_req_addr, 32'h2);
    chk("s1_c2_dec_valid", dec_valid, 1'b1);
    chk("s1_c2_dec_pc", dec_pc, 32'h0);
    repeat (20) @(negedge clk);
    chk("s1_progress", (exp_pc > 32'd10), 1'b1);

    step();
    rst = 1'b1;
    dec_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    exp_pc = '0;
    pops = 0;
    repeat (20) @(negedge clk);
    chk("s2_full_req_valid", imem_req_valid, 1'b0);
    chk("s2_full_dec_valid", dec_valid, 1'b1);
    chk("s2_full_dec_pc", dec_pc, 32'h0);
    step();
    imem_req_ready = 1'b0;
    dec_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dec_valid) n++;
    end
    chk("s2_fill_count", n, 8);

    step();
    mem_lat = 3;
    imem_req_ready = 1'b1;
    wait_fire(ok);
    chk("s3_fire_tmo", ok, 1'b1);
    chk("s3_fire_addr", imem_req_addr, 32'h8);
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'd7;
    @(negedge clk);
    chk("s3_wait_req_valid", imem_req_valid, 1'b0);
    step();
    redirect_valid = 1'b0;
    exp_pc = 32'd7;
    wait_req(ok);
    chk("s3_req_tmo", ok, 1'b1);
    chk("s3_req_addr", imem_req_addr, 32'h6);
    wait_dec(ok);
    chk("s3_dec_tmo", ok, 1'b1);
    chk("s3_first_dec_pc", dec_pc, 32'd7);
    step();
    imem_req_ready = 1'b0;
    drain(ok);
    chk("s3_drain_tmo", ok, 1'b1);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_insn_pushed", perf_insn_pushed, 32'(pops));
    chk("perf_resp_dropped", perf_resp_dropped, 32'd1);
    chk("perf_stall_full_nz", (perf_stall_full != 0), 1'b1);
`endif

    step();
    imem_req_ready = 1'b1;
    wait_fire(ok);
    chk("s4_fire_tmo", ok, 1'b1);
    step();
    step();
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'd20;
    step();
    redirect_valid = 1'b0;
    exp_pc = 32'd20;
    wait_req(ok);
    chk("s4_req_tmo", ok, 1'b1);
    chk("s4_req_addr", imem_req_addr, 32'd20);
    wait_dec(ok);
    chk("s4_dec_tmo", ok, 1'b1);
    chk("s4_first_dec_pc", dec_pc, 32'd20);

    step();
    mem_lat = 1;
    imem_req_ready = 1'b0;
    drain(ok);
    chk("s5_drain_tmo", ok, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("s5_hold_valid", imem_req_valid, 1'b1);
      chk("s5_hold_addr", imem_req_addr, exp_pc);
    end
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'd33;
    @(negedge clk);
    chk("s5_withdrawn", imem_req_valid, 1'b0);
    step();
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    exp_pc = 32'd33;
    wait_req(ok);
    chk("s5_req_tmo", ok, 1'b1);
    chk("s5_req_addr", imem_req_addr, 32'd32);
    wait_dec(ok);
    chk("s5_dec_tmo", ok, 1'b1);
    chk("s5_first_dec_pc", dec_pc, 32'd33);
    repeat (10) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
